scoreboard: RTL
===============

SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 Parameter: NREGS, default 32, number of architectural registers (x0..x31).
REQ-002 Parameter: RFADDR, default 5, register address width (imhotep_pkg value).
REQ-003 Parameter: CNTW, default 2, width of each per-register pending counter; max count CMAX = 2^CNTW-1.
REQ-004 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_ni  input  1  asynchronous active-low reset.
REQ-006 Port: query_1_i  input  RFADDR  rs1 address from decoder.
REQ-007 Port: query_2_i  input  RFADDR  rs2 address from decoder.
REQ-008 Port: query_answer_1_o  output  1  rs1 has a pending write (decoder stalls).
REQ-009 Port: query_answer_2_o  output  1  rs2 has a pending write.
REQ-010 Port: commit_i  input  RFADDR  rd of the instruction issuing this cycle; 0 = none.
REQ-011 Port: commit_ready_o  output  1  rd counter can accept another pending write.
REQ-012 Port: alu_wb_valid_i / alu_wb_addr_i  input  1 / RFADDR  ALU writeback release.
REQ-013 Port: lsu_wb_valid_i / lsu_wb_addr_i  input  1 / RFADDR  LSU writeback release.
REQ-014 Port: flush_i  input  1  discard all pending state (branch/jump redirect).
REQ-015 Port: busy_o  output  NREGS  bit r = counter r nonzero.
REQ-016 Port: idle_o  output  1  all counters zero.
REQ-017 Port: err_o  output  1  registered one-cycle protocol-error pulse.

Function
REQ-018 State: one CNTW-bit pending counter per register 1..NREGS-1; register 0 has no counter, reads as 0.
REQ-019 Query answers are combinational from registered counters only: answer = (count[addr] != 0); no same-cycle writeback bypass.
REQ-020 Query of address 0 always answers 0.
REQ-021 commit_ready_o = (commit_i == 0) or (count[commit_i] < CMAX), combinational.
REQ-022 Commit accepted when commit_i != 0 and count[commit_i] < CMAX: counter +1 next edge.
REQ-023 Commit with count[commit_i] == CMAX is dropped (counter unchanged) and err_o pulses next cycle.
REQ-024 Release accepted when port valid, address != 0, and count[addr] > 0: counter -1 next edge.
REQ-025 Release with count[addr] == 0 is dropped (no underflow wrap) and err_o pulses next cycle.
REQ-026 Release with valid and address 0 is ignored, no error.
REQ-027 Same-cycle events on one register combine as net delta: +1 commit, -1 per release; commit + one release = unchanged; two releases = -2.
REQ-028 Saturation/underflow checks in REQ-023/025 use the net delta: commit at CMAX with a same-cycle release is accepted (no error); two releases at count 1 → count 0, err_o pulses.
REQ-029 Events on different registers in the same cycle are independent.
REQ-030 flush_i clears all counters next edge, overrides same-cycle commit/release, suppresses err_o for that cycle.
REQ-031 busy_o and idle_o derive combinationally from registered counters.
REQ-032 err_o is a flop; high exactly one cycle after any dropped event, otherwise low.

Reset
REQ-033 rst_ni low asynchronously clears all counters and err_o; busy_o = 0, idle_o = 1, query answers 0, commit_ready_o = 1 while in reset and after.
REQ-034 Reset asserted mid-operation discards all pending state; no release is required afterwards.
REQ-035 First state update occurs on the first rising clk_i edge after rst_ni deasserts.

Verification
REQ-036 Reset, commit_i=5 one cycle, query_1_i=5 → query_answer_1_o=1 next cycle, busy_o=32'h20; alu_wb 5 → answer 0, idle_o=1 one cycle later.
REQ-037 Commit x7 three times (CNTW=2) → commit_ready_o=0 for rd=7; fourth commit → count stays 3, err_o=1 one cycle.
REQ-038 count[3]=1, alu_wb and lsu_wb both release 3 same cycle → count 0, err_o=1; count[3]=1, commit 3 + alu release 3 same cycle → count 1, err_o=0.
REQ-039 commit_i=0, release address 0, query 0 → no state change, answers 0, err_o=0.
REQ-040 Counters x1=2, x9=1; flush_i with same-cycle commit x4 → all counters 0, idle_o=1, err_o=0.
REQ-041 Counters nonzero, rst_ni pulsed low between edges → busy_o=0 immediately, no clock required.

Source files
------------

// File: rtl/scoreboard.sv
// Register scoreboard: one saturating pending-write counter per architectural
// register, raised on issue and lowered on ALU/LSU writeback.
module scoreboard #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned RFADDR = 5,
  parameter int unsigned CNTW   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [RFADDR-1:0] query_1_i,
  input  logic [RFADDR-1:0] query_2_i,
  output logic              query_answer_1_o,
  output logic              query_answer_2_o,
  input  logic [RFADDR-1:0] commit_i,
  output logic              commit_ready_o,
  input  logic              alu_wb_valid_i,
  input  logic [RFADDR-1:0] alu_wb_addr_i,
  input  logic              lsu_wb_valid_i,
  input  logic [RFADDR-1:0] lsu_wb_addr_i,
  input  logic              flush_i,
  output logic [NREGS-1:0]  busy_o,
  output logic              idle_o,
  output logic              err_o
);

  localparam int unsigned CMAX = (1 << CNTW) - 1;
  localparam int unsigned NETW = CNTW + 2;

  logic [CNTW-1:0]  r_cnt [NREGS];
  logic [CNTW-1:0]  w_nxt [NREGS];
  logic             r_err;
  logic             w_err;
  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_full;
  logic             w_inc;
  logic [1:0]       w_dec;
  logic [NETW-1:0]  w_sum;

  // Net delta per register, biased by +2 so underflow stays non-negative
  always_comb begin
    w_err    = 1'b0;
    w_inc    = 1'b0;
    w_dec    = 2'd0;
    w_sum    = '0;
    w_nxt[0] = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      w_inc = (commit_i == RFADDR'(r));
      w_dec = 2'({1'b0, alu_wb_valid_i && (alu_wb_addr_i == RFADDR'(r))}) +
              2'({1'b0, lsu_wb_valid_i && (lsu_wb_addr_i == RFADDR'(r))});
      w_sum = NETW'(r_cnt[r]) + NETW'(w_inc) + NETW'(2) - NETW'(w_dec);
      if (w_sum < NETW'(2)) begin
        w_nxt[r] = '0;
        w_err    = 1'b1;
      end else if (w_sum > NETW'(CMAX + 2)) begin
        w_nxt[r] = CNTW'(CMAX);
        w_err    = 1'b1;
      end else begin
        w_nxt[r] = CNTW'(w_sum - NETW'(2));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NREGS; r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else if (flush_i) begin
      for (int unsigned r = 0; r < NREGS; r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) r_cnt[r] <= w_nxt[r];
      r_err <= w_err;
    end
  end

  always_comb begin
    w_busy = '0;
    w_full = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
      w_full[r] = (r_cnt[r] == CNTW'(CMAX));
    end
  end

  assign query_answer_1_o = w_busy[query_1_i];
  assign query_answer_2_o = w_busy[query_2_i];
  assign commit_ready_o   = (commit_i == '0) || !w_full[commit_i];
  assign busy_o           = w_busy;
  assign idle_o           = (w_busy == '0);
  assign err_o            = r_err;

endmodule
